// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Optional performance counters are enabled with the PIPE_PERF_EN macro.
package pipe_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LD_STALL = 2'd1,
    BR_FLUSH = 2'd2,
    MEM_WAIT = 2'd3
  } hz_state_e;

  localparam logic [4:0] XZR_IDX = 5'd31;

  // Control bundle order: pcWrite, ifIdWrite, ifIdFlush, idExWrite, idExBubble
  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic if_id_flush;
    logic id_ex_write;
    logic id_ex_bubble;
  } ctrl_t;

  localparam ctrl_t CTRL_RUN   = 5'b11010;
  localparam ctrl_t CTRL_STALL = 5'b00011;
  localparam ctrl_t CTRL_FLUSH = 5'b11111;
  localparam ctrl_t CTRL_HOLD  = 5'b00000;
  localparam ctrl_t CTRL_RST   = 5'b00101;

  // Width of the remaining-cycle counter, never narrower than one bit.
  function automatic int cnt_width(input int max_cycles);
    int w;
    w = $clog2(max_cycles + 1);
    if (w < 1) begin
      return 1;
    end else begin
      return w;
    end
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-controller bundle: pipeline status in, register-enable controls out.
// stallCnt/flushCnt carry data only when PIPE_PERF_EN is defined.
interface pipe_hazard_ctrl_if #(
  parameter int PERF_W = 32
);
  logic              memRead_EX;
  logic              RegWrite_EX;
  logic [4:0]        targetReg_EX;
  logic [4:0]        rs1_ID;
  logic [4:0]        rs2_ID;
  logic              useRs2_ID;
  logic              brTaken_EX;
  logic              memBusy;
  logic              pcWrite;
  logic              ifIdWrite;
  logic              ifIdFlush;
  logic              idExWrite;
  logic              idExBubble;
  logic [PERF_W-1:0] stallCnt;
  logic [PERF_W-1:0] flushCnt;

  modport master (
    output memRead_EX, RegWrite_EX, targetReg_EX, rs1_ID, rs2_ID, useRs2_ID,
           brTaken_EX, memBusy,
    input  pcWrite, ifIdWrite, ifIdFlush, idExWrite, idExBubble, stallCnt, flushCnt
  );

  modport slave (
    input  memRead_EX, RegWrite_EX, targetReg_EX, rs1_ID, rs2_ID, useRs2_ID,
           brTaken_EX, memBusy,
    output pcWrite, ifIdWrite, ifIdFlush, idExWrite, idExBubble, stallCnt, flushCnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl_load_use.sv
// Combinational load-use hazard compare between the load in EX and the sources in ID.
// The zero register never creates a dependency.
module load_use_detect
  import pipe_hazard_ctrl_pkg::*;
(
  input  logic       mem_read,
  input  logic       reg_write,
  input  logic [4:0] target_reg,
  input  logic [4:0] rs1,
  input  logic [4:0] rs2,
  input  logic       use_rs2,
  output logic       ld_use
);

  logic rs1_hit_s;
  logic rs2_hit_s;

  assign rs1_hit_s = (target_reg == rs1);
  assign rs2_hit_s = use_rs2 & (target_reg == rs2);
  assign ld_use    = mem_read & reg_write & (target_reg != XZR_IDX) & (rs1_hit_s | rs2_hit_s);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, branch flushes and memory-busy freeze.
// Define PIPE_PERF_EN to enable the saturating stall/flush cycle counters.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int FLUSH_CYCLES      = 1,
  parameter int PERF_W            = 32
) (
  input  logic             clk,
  input  logic             reset,
  pipe_hazard_ctrl_if.slave hz
);

  localparam int CNT_MAX = (LOAD_STALL_CYCLES > FLUSH_CYCLES) ? LOAD_STALL_CYCLES : FLUSH_CYCLES;
  localparam int CNT_W   = cnt_width(CNT_MAX);

  hz_state_e        state_r, state_nxt_s;
  hz_state_e        resume_r, resume_nxt_s;
  hz_state_e        active_s;
  logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
  logic             pend_br_r, pend_nxt_s;
  logic             ld_use_s;
  logic             branch_s;
  logic             is_stall_s;
  logic             is_flush_s;
  ctrl_t            ctrl_s;
  ctrl_t            ctrl_out_s;

  load_use_detect u_ld_use (
    .mem_read   (hz.memRead_EX),
    .reg_write  (hz.RegWrite_EX),
    .target_reg (hz.targetReg_EX),
    .rs1        (hz.rs1_ID),
    .rs2        (hz.rs2_ID),
    .use_rs2    (hz.useRs2_ID),
    .ld_use     (ld_use_s)
  );

  // While frozen, the state that was interrupted is what resumes afterwards.
  assign active_s = (state_r == MEM_WAIT) ? resume_r : state_r;
  assign branch_s = hz.brTaken_EX | pend_br_r;

  // FSM state, remaining-cycle counter and pending-branch register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= RUN;
      resume_r  <= RUN;
      cnt_r     <= {CNT_W{1'b0}};
      pend_br_r <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      resume_r  <= resume_nxt_s;
      cnt_r     <= cnt_nxt_s;
      pend_br_r <= pend_nxt_s;
    end
  end

  // Next-state and Mealy control decode; priority busy > branch > load-use.
  always_comb begin
    state_nxt_s  = state_r;
    resume_nxt_s = resume_r;
    cnt_nxt_s    = cnt_r;
    pend_nxt_s   = pend_br_r;
    ctrl_s       = CTRL_RUN;
    is_stall_s   = 1'b0;
    is_flush_s   = 1'b0;
    if (hz.memBusy) begin
      ctrl_s      = CTRL_HOLD;
      state_nxt_s = MEM_WAIT;
      pend_nxt_s  = pend_br_r | hz.brTaken_EX;
      if (state_r != MEM_WAIT) begin
        resume_nxt_s = state_r;
      end else begin
        resume_nxt_s = resume_r;
      end
    end else if (branch_s) begin
      ctrl_s       = CTRL_FLUSH;
      is_flush_s   = 1'b1;
      pend_nxt_s   = 1'b0;
      resume_nxt_s = RUN;
      if (FLUSH_CYCLES > 32'sd1) begin
        state_nxt_s = BR_FLUSH;
        cnt_nxt_s   = CNT_W'(FLUSH_CYCLES - 1);
      end else begin
        state_nxt_s = RUN;
        cnt_nxt_s   = {CNT_W{1'b0}};
      end
    end else begin
      resume_nxt_s = RUN;
      case (active_s)
        BR_FLUSH: begin
          ctrl_s     = CTRL_FLUSH;
          is_flush_s = 1'b1;
          if (cnt_r > CNT_W'(1)) begin
            state_nxt_s = BR_FLUSH;
            cnt_nxt_s   = cnt_r - CNT_W'(1);
          end else begin
            state_nxt_s = RUN;
            cnt_nxt_s   = {CNT_W{1'b0}};
          end
        end
        LD_STALL: begin
          ctrl_s     = CTRL_STALL;
          is_stall_s = 1'b1;
          if (cnt_r > CNT_W'(1)) begin
            state_nxt_s = LD_STALL;
            cnt_nxt_s   = cnt_r - CNT_W'(1);
          end else begin
            state_nxt_s = RUN;
            cnt_nxt_s   = {CNT_W{1'b0}};
          end
        end
        RUN: begin
          if (ld_use_s) begin
            ctrl_s     = CTRL_STALL;
            is_stall_s = 1'b1;
            if (LOAD_STALL_CYCLES > 32'sd1) begin
              state_nxt_s = LD_STALL;
              cnt_nxt_s   = CNT_W'(LOAD_STALL_CYCLES - 1);
            end else begin
              state_nxt_s = RUN;
              cnt_nxt_s   = {CNT_W{1'b0}};
            end
          end else begin
            ctrl_s      = CTRL_RUN;
            state_nxt_s = RUN;
            cnt_nxt_s   = {CNT_W{1'b0}};
          end
        end
        default: begin
          ctrl_s      = CTRL_RUN;
          state_nxt_s = RUN;
          cnt_nxt_s   = {CNT_W{1'b0}};
        end
      endcase
    end
  end

  // Reset forces a NOP into both pipeline registers and holds the PC.
  always_comb begin
    ctrl_out_s = CTRL_RST;
    if (reset) begin
      ctrl_out_s = CTRL_RST;
    end else begin
      ctrl_out_s = ctrl_s;
    end
  end

  assign hz.pcWrite    = ctrl_out_s.pc_write;
  assign hz.ifIdWrite  = ctrl_out_s.if_id_write;
  assign hz.ifIdFlush  = ctrl_out_s.if_id_flush;
  assign hz.idExWrite  = ctrl_out_s.id_ex_write;
  assign hz.idExBubble = ctrl_out_s.id_ex_bubble;

`ifdef PIPE_PERF_EN
  logic [PERF_W-1:0] stall_cnt_r;
  logic [PERF_W-1:0] flush_cnt_r;

  // Saturating bubble counters; busy cycles produce no bubble and so hold.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_r <= {PERF_W{1'b0}};
      flush_cnt_r <= {PERF_W{1'b0}};
    end else begin
      if (is_stall_s && (stall_cnt_r != {PERF_W{1'b1}})) begin
        stall_cnt_r <= stall_cnt_r + {{(PERF_W-1){1'b0}}, 1'b1};
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
      if (is_flush_s && (flush_cnt_r != {PERF_W{1'b1}})) begin
        flush_cnt_r <= flush_cnt_r + {{(PERF_W-1){1'b0}}, 1'b1};
      end else begin
        flush_cnt_r <= flush_cnt_r;
      end
    end
  end

  assign hz.stallCnt = stall_cnt_r;
  assign hz.flushCnt = flush_cnt_r;
`else
  assign hz.stallCnt = {PERF_W{1'b0}};
  assign hz.flushCnt = {PERF_W{1'b0}};
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench: instance a uses default parameters, instance b uses
// two-cycle stall/flush with 4-bit counters (saturation checked with PIPE_PERF_EN).
module tb_pipe_hazard_ctrl;

  localparam logic [4:0] E_RUN   = 5'b11010;
  localparam logic [4:0] E_STALL = 5'b00011;
  localparam logic [4:0] E_FLUSH = 5'b11111;
  localparam logic [4:0] E_HOLD  = 5'b00000;
  localparam logic [4:0] E_RST   = 5'b00101;

  logic clk;
  logic rst_a;
  logic rst_b;
  int   errors;
  int   checks;

  pipe_hazard_ctrl_if #(.PERF_W(32)) ifa ();
  pipe_hazard_ctrl_if #(.PERF_W(4))  ifb ();

  pipe_hazard_ctrl #(.LOAD_STALL_CYCLES(1), .FLUSH_CYCLES(1), .PERF_W(32)) dut_a (
    .clk   (clk),
    .reset (rst_a),
    .hz    (ifa.slave)
  );

  pipe_hazard_ctrl #(.LOAD_STALL_CYCLES(2), .FLUSH_CYCLES(2), .PERF_W(4)) dut_b (
    .clk   (clk),
    .reset (rst_b),
    .hz    (ifb.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [4:0] out_a();
    return {ifa.pcWrite, ifa.ifIdWrite, ifa.ifIdFlush, ifa.idExWrite, ifa.idExBubble};
  endfunction

  function automatic logic [4:0] out_b();
    return {ifb.pcWrite, ifb.ifIdWrite, ifb.ifIdFlush, ifb.idExWrite, ifb.idExBubble};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_a(input logic mr, input logic rw, input logic [4:0] tg,
                         input logic [4:0] r1, input logic [4:0] r2, input logic u2,
                         input logic br, input logic busy);
    @(negedge clk);
    ifa.memRead_EX = mr; ifa.RegWrite_EX = rw; ifa.targetReg_EX = tg;
    ifa.rs1_ID = r1; ifa.rs2_ID = r2; ifa.useRs2_ID = u2;
    ifa.brTaken_EX = br; ifa.memBusy = busy;
    #1;
  endtask

  task automatic drive_b(input logic mr, input logic rw, input logic [4:0] tg,
                         input logic [4:0] r1, input logic [4:0] r2, input logic u2,
                         input logic br, input logic busy);
    @(negedge clk);
    ifb.memRead_EX = mr; ifb.RegWrite_EX = rw; ifb.targetReg_EX = tg;
    ifb.rs1_ID = r1; ifb.rs2_ID = r2; ifb.useRs2_ID = u2;
    ifb.brTaken_EX = br; ifb.memBusy = busy;
    #1;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst_a = 1'b1;
    rst_b = 1'b1;
    ifa.memRead_EX = 1'b0; ifa.RegWrite_EX = 1'b0; ifa.targetReg_EX = 5'd0;
    ifa.rs1_ID = 5'd0; ifa.rs2_ID = 5'd0; ifa.useRs2_ID = 1'b0;
    ifa.brTaken_EX = 1'b0; ifa.memBusy = 1'b0;
    ifb.memRead_EX = 1'b0; ifb.RegWrite_EX = 1'b0; ifb.targetReg_EX = 5'd0;
    ifb.rs1_ID = 5'd0; ifb.rs2_ID = 5'd0; ifb.useRs2_ID = 1'b0;
    ifb.brTaken_EX = 1'b0; ifb.memBusy = 1'b0;

    @(negedge clk); #1;
    chk("a_reset_out", 32'(out_a()), 32'(E_RST));
    chk("b_reset_out", 32'(out_b()), 32'(E_RST));
    chk("a_reset_stallcnt", ifa.stallCnt, 32'd0);
    @(negedge clk);
    rst_a = 1'b0;
    rst_b = 1'b0;

    // Instance a: single-cycle stall and flush
    drive_a(1'b1, 1'b1, 5'd2, 5'd2, 5'd0, 1'b0, 1'b0, 1'b0);
    chk("a_ldu_rs1", 32'(out_a()), 32'(E_STALL));
    drive_a(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    chk("a_ldu_then_run", 32'(out_a()), 32'(E_RUN));
    drive_a(1'b1, 1'b1, 5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0);
    chk("a_ldu_rs2", 32'(out_a()), 32'(E_STALL));
    drive_a(1'b1, 1'b1, 5'd5, 5'd0, 5'd5, 1'b0, 1'b0, 1'b0);
    chk("a_rs2_unused", 32'(out_a()), 32'(E_RUN));
    drive_a(1'b1, 1'b0, 5'd2, 5'd2, 5'd0, 1'b0, 1'b0, 1'b0);
    chk("a_no_regwrite", 32'(out_a()), 32'(E_RUN));
    drive_a(1'b0, 1'b1, 5'd2, 5'd2, 5'd0, 1'b0, 1'b0, 1'b0);
    chk("a_no_memread", 32'(out_a()), 32'(E_RUN));
    drive_a(1'b1, 1'b1, 5'd31, 5'd31, 5'd31, 1'b1, 1'b0, 1'b0);
    chk("a_xzr", 32'(out_a()), 32'(E_RUN));
    drive_a(1'b1, 1'b1, 5'd3, 5'd3, 5'd0, 1'b0, 1'b1, 1'b0);
    chk("a_br_beats_ldu", 32'(out_a()), 32'(E_FLUSH));
    drive_a(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    chk("a_br_then_run", 32'(out_a()), 32'(E_RUN));

    drive_a(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1);
    chk("a_busy1", 32'(out_a()), 32'(E_HOLD));
    drive_a(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
    chk("a_busy2", 32'(out_a()), 32'(E_HOLD));
    drive_a(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
    chk("a_busy3", 32'(out_a()), 32'(E_HOLD));
    drive_a(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    chk("a_pend_br_flush", 32'(out_a()), 32'(E_FLUSH));
    drive_a(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    chk("a_pend_cleared", 32'(out_a()), 32'(E_RUN));

    drive_a(1'b1, 1'b1, 5'd4, 5'd4, 5'd0, 1'b0, 1'b0, 1'b1);
    chk("a_busy_over_ldu", 32'(out_a()), 32'(E_HOLD));
    drive_a(1'b1, 1'b1, 5'd4, 5'd4, 5'd0, 1'b0, 1'b0, 1'b0);
    chk("a_ldu_after_busy", 32'(out_a()), 32'(E_STALL));
    drive_a(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    chk("a_run_after_busy", 32'(out_a()), 32'(E_RUN));

    // Instance b: two-cycle stall and flush
    drive_b(1'b1, 1'b1, 5'd7, 5'd7, 5'd0, 1'b0, 1'b0, 1'b0);
    chk("b_ld1", 32'(out_b()), 32'(E_STALL));
    drive_b(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    chk("b_ld2", 32'(out_b()), 32'(E_STALL));
    drive_b(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    chk("b_ld_done", 32'(out_b()), 32'(E_RUN));

    drive_b(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
    chk("b_fl1", 32'(out_b()), 32'(E_FLUSH));
    drive_b(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    chk("b_fl2", 32'(out_b()), 32'(E_FLUSH));
    drive_b(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    chk("b_fl_done", 32'(out_b()), 32'(E_RUN));

    drive_b(1'b1, 1'b1, 5'd7, 5'd7, 5'd0, 1'b0, 1'b0, 1'b0);
    chk("b_abort_ld", 32'(out_b()), 32'(E_STALL));
    drive_b(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
    chk("b_abort_br1", 32'(out_b()), 32'(E_FLUSH));
    drive_b(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    chk("b_abort_br2", 32'(out_b()), 32'(E_FLUSH));
    drive_b(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    chk("b_abort_done", 32'(out_b()), 32'(E_RUN));

    drive_b(1'b1, 1'b1, 5'd9, 5'd0, 5'd9, 1'b1, 1'b0, 1'b0);
    chk("b_stall_pre_busy", 32'(out_b()), 32'(E_STALL));
    drive_b(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
    chk("b_busy_mid_stall", 32'(out_b()), 32'(E_HOLD));
    drive_b(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    chk("b_stall_resumed", 32'(out_b()), 32'(E_STALL));
    drive_b(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    chk("b_stall_resume_done", 32'(out_b()), 32'(E_RUN));

`ifndef PIPE_PERF_EN
    chk("b_stallcnt_tied", 32'(ifb.stallCnt), 32'd0);
    chk("b_flushcnt_tied", 32'(ifb.flushCnt), 32'd0);
`endif

    drive_b(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
    chk("b_rst_fl1", 32'(out_b()), 32'(E_FLUSH));
    @(negedge clk);
    rst_b = 1'b1;
    ifb.brTaken_EX = 1'b0;
    #1;
    chk("b_rst_mid_flush", 32'(out_b()), 32'(E_RST));
    @(negedge clk);
    rst_b = 1'b0;
    #1;
    chk("b_rst_then_run", 32'(out_b()), 32'(E_RUN));

`ifdef PIPE_PERF_EN
    chk("b_cnt_cleared", 32'(ifb.stallCnt), 32'd0);
    for (int i = 0; i < 20; i++) begin
      drive_b(1'b1, 1'b1, 5'd7, 5'd7, 5'd0, 1'b0, 1'b0, 1'b0);
    end
    drive_b(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    chk("b_stallcnt_sat", 32'(ifb.stallCnt), 32'd15);
    chk("b_flushcnt_zero", 32'(ifb.flushCnt), 32'd0);
    drive_b(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
    drive_b(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
    drive_b(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    drive_b(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    chk("b_flushcnt_two", 32'(ifb.flushCnt), 32'd2);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
